// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the SPI register controller: FSM state encoding and
// the command byte values recognised on the command (dc=0) channel.
package reg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_e;

    localparam logic [7:0] CMD_ADDR_SET = 8'h2A;
    localparam logic [7:0] CMD_DATA_WR  = 8'h3A;
    localparam logic [7:0] CMD_DATA_RD  = 8'h3B;

    // True for any byte the controller treats as a valid command.
    function automatic logic is_known_cmd(input logic [7:0] b);
        return (b == CMD_ADDR_SET) || (b == CMD_DATA_WR) || (b == CMD_DATA_RD);
    endfunction

endpackage

// File: rtl/reg_ptr.sv
// Register address pointer: parallel load, optional increment, and wrap from
// REG_CNT-1 back to 0 so the pointer never leaves the register map.
module reg_ptr #(
    parameter int ADDR_W  = 4,
    parameter int REG_CNT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] ptr_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(REG_CNT - 1);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // Next pointer: load has priority over increment.
    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_val_i;
        end else if (inc_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ADDR_W'(1);
        end
    end

    // Pointer register, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reg_ctrl.sv
// SPI byte-stream register controller. Command bytes (dc=0) select address
// set / write / read mode; data bytes (dc=1) then set the base address or
// produce one-cycle register read/write strobes at an auto-incrementing
// pointer. All strobes are registered and appear one cycle after the byte.
module reg_ctrl
    import reg_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int REG_CNT  = 16,
    parameter int AUTO_INC = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dc_i,
    input  logic              spi_byte_vld_i,
    input  logic [7:0]        spi_byte_data_i,
    output logic              reg_rd_en_o,
    output logic [ADDR_W-1:0] reg_rd_addr_o,
    output logic              reg_wr_en_o,
    output logic [ADDR_W-1:0] reg_wr_addr_o,
    output logic [7:0]        reg_wr_data_o,
    output logic              cmd_err_o
);

    localparam logic [ADDR_W:0] CNT_W       = (ADDR_W + 1)'(REG_CNT);
    localparam logic            AUTO_INC_EN = (AUTO_INC != 0);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              err_q, err_d;

    logic              ptr_load;
    logic [ADDR_W-1:0] ptr_load_val;
    logic              ptr_inc;
    logic [ADDR_W-1:0] ptr;

    logic [ADDR_W-1:0] byte_addr;
    logic [ADDR_W-1:0] byte_addr_clamped;

    // Out-of-range addresses in an ADDR_SET payload fold to register 0.
    assign byte_addr         = spi_byte_data_i[ADDR_W-1:0];
    assign byte_addr_clamped = ({1'b0, byte_addr} < CNT_W) ? byte_addr : '0;

    reg_ptr #(
        .ADDR_W (ADDR_W),
        .REG_CNT(REG_CNT)
    ) u_ptr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (ptr_load),
        .load_val_i(ptr_load_val),
        .inc_i     (ptr_inc),
        .ptr_o     (ptr)
    );

    // Next-state and strobe decode for each accepted byte.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        ptr_load     = 1'b0;
        ptr_load_val = base_q;
        ptr_inc      = 1'b0;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        err_d        = 1'b0;

        if (spi_byte_vld_i) begin
            if (!dc_i) begin
                // A command byte restarts the transfer from any state.
                case (spi_byte_data_i)
                    CMD_ADDR_SET: state_d = ST_ADDR;
                    CMD_DATA_WR: begin
                        state_d  = ST_WR;
                        ptr_load = 1'b1;
                    end
                    CMD_DATA_RD: begin
                        state_d  = ST_RD;
                        ptr_load = 1'b1;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        err_d   = !is_known_cmd(spi_byte_data_i);
                    end
                endcase
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        base_d       = byte_addr_clamped;
                        ptr_load     = 1'b1;
                        ptr_load_val = byte_addr_clamped;
                        state_d      = ST_IDLE;
                    end
                    ST_WR: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr;
                        wr_data_d = spi_byte_data_i;
                        ptr_inc   = AUTO_INC_EN;
                    end
                    ST_RD: begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = ptr;
                        ptr_inc   = AUTO_INC_EN;
                    end
                    default: ;
                endcase
            end
        end
    end

    // State, base address and registered outputs; reset discards any byte.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign reg_rd_en_o   = rd_en_q;
    assign reg_rd_addr_o = rd_addr_q;
    assign reg_wr_en_o   = wr_en_q;
    assign reg_wr_addr_o = wr_addr_q;
    assign reg_wr_data_o = wr_data_q;
    assign cmd_err_o     = err_q;

endmodule

// File: doc/reg_ctrl.md
REG_CTRL -- requirements
Module: reg_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4: register address width in bits, range 1..8.
REQ-002 Parameter REG_CNT, default 16: number of addressable registers, 1..2**ADDR_W.
REQ-003 Parameter AUTO_INC, default 1: 1 = address increments after each data byte; 0 = address holds.
REQ-004 clk_i  in  1  single system clock; all logic on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 dc_i  in  1  0 = command byte, 1 = data byte; sampled only when spi_byte_vld_i=1.
REQ-007 spi_byte_vld_i  in  1  one-cycle strobe, received SPI byte valid.
REQ-008 spi_byte_data_i  in  8  received SPI byte.
REQ-009 reg_rd_en_o  out  1  one-cycle register read strobe.
REQ-010 reg_rd_addr_o  out  ADDR_W  read address, valid with reg_rd_en_o.
REQ-011 reg_wr_en_o  out  1  one-cycle register write strobe.
REQ-012 reg_wr_addr_o  out  ADDR_W  write address, valid with reg_wr_en_o.
REQ-013 reg_wr_data_o  out  8  write data, valid with reg_wr_en_o.
REQ-014 cmd_err_o  out  1  one-cycle strobe, unrecognised command byte.

Function
REQ-015 Commands: 0x2A ADDR_SET, 0x3A DATA_WR, 0x3B DATA_RD; any other byte is unrecognised.
REQ-016 FSM states IDLE, ADDR, WR, RD; reset state IDLE.
REQ-017 Command byte (vld=1, dc=0), in any state: 0x2A->ADDR, 0x3A->WR, 0x3B->RD, other->IDLE with cmd_err_o=1 next cycle.
REQ-018 A DATA_WR or DATA_RD command loads the address pointer with the base address; ADDR_SET does not change it.
REQ-019 Base address: 0 after reset; replaced only by an accepted ADDR byte.
REQ-020 Data byte in ADDR: base and pointer <= spi_byte_data_i[ADDR_W-1:0]; values >= REG_CNT load 0; FSM -> IDLE.
REQ-021 Data byte in WR: next cycle reg_wr_en_o=1, reg_wr_addr_o=pointer, reg_wr_data_o=byte.
REQ-022 Data byte in RD: next cycle reg_rd_en_o=1, reg_rd_addr_o=pointer.
REQ-023 Data byte in IDLE: ignored, no strobe, no error.
REQ-024 After each WR/RD data byte with AUTO_INC=1: pointer <= pointer+1; wraps REG_CNT-1 -> 0.
REQ-025 With AUTO_INC=0 the pointer is unchanged by data bytes.
REQ-026 Latency: every output strobe is registered and asserts exactly 1 cycle after the accepting vld cycle, for 1 cycle.
REQ-027 Back-to-back vld on consecutive cycles are all accepted; no byte dropped.
REQ-028 At most one of reg_rd_en_o, reg_wr_en_o, cmd_err_o is high in any cycle.
REQ-029 Address/data outputs hold their last value when strobes are low.
REQ-030 dc_i and spi_byte_data_i are don't-care when spi_byte_vld_i=0.

Reset
REQ-031 rst_i=1 at a rising edge: FSM->IDLE, base and pointer->0, all outputs->0 on that edge.
REQ-032 Reset mid-transfer aborts the command; post-reset data bytes are ignored until a new command.
REQ-033 A vld coincident with rst_i=1 is discarded.

Structure
REQ-034 Shared package reg_ctrl_pkg holds the state enum and command byte constants (CMD_ADDR_SET, CMD_DATA_WR, CMD_DATA_RD).
REQ-035 One sub-module reg_ptr: address pointer with load, increment-enable and REG_CNT wrap; all else in reg_ctrl.
REQ-036 Target size 120-400 lines RTL; no memories, no clock-domain crossing.

Verification (ADDR_W=4, REG_CNT=16, AUTO_INC=1 unless noted)
REQ-037 Reset, cmd 0x3B, 3 data bytes -> reg_rd_en_o pulses with addr 0,1,2, each 1 cycle after its vld.
REQ-038 Cmd 0x2A, data 0x0E, cmd 0x3A, data 0x11,0x22,0x33 -> writes (0xE,0x11),(0xF,0x22),(0x0,0x33).
REQ-039 Cmd 0x55 then data 0xAA -> cmd_err_o one pulse; no rd/wr strobe.
REQ-040 REG_CNT=10: cmd 0x2A, data 0x0C -> base 0; cmd 0x3B, 11 data bytes -> addr 0..9 then 0.
REQ-041 Cmd 0x3B, 2 data bytes, rst_i for 1 cycle, 1 data byte -> 2 read strobes only; outputs 0 after reset.
REQ-042 AUTO_INC=0: cmd 0x2A, data 0x05, cmd 0x3B, 4 data bytes on consecutive cycles -> 4 read strobes, all addr 5.
